// File: rtl/ball_pkg.sv
// ball_pkg: shared types and defaults for the LED ping-pong game engine.
//   state_e        : ball FSM states (IDLE, MOVE_R, MOVE_L, OVER)
//   SIDE_L/SIDE_R  : encoding for serve side and winner
//   DEF_*          : default track length, step divider and winning score
package ball_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_R = 2'd1,
    MOVE_L = 2'd2,
    OVER   = 2'd3
  } state_e;

  localparam logic SIDE_L = 1'b0;
  localparam logic SIDE_R = 1'b1;

  localparam int DEF_NPOS      = 8;
  localparam int DEF_STEP_DIV  = 600000;
  localparam int DEF_WIN_SCORE = 7;

endpackage

// File: rtl/ball_step_div.sv
// ball_step_div: ball step pacing divider.
//   clk_i   : system clock
//   reset_i : synchronous active-high reset
//   clr_i   : restart the step interval (wins over en_i)
//   en_i    : count only while the ball is in flight
//   tick_o  : one-cycle pulse on the last cycle of each STEP_DIV interval
module ball_step_div
  import ball_pkg::*;
#(
  parameter int STEP_DIV = DEF_STEP_DIV
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int               CNT_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == CNT_LAST);

  // Next count: clear, wrap at the last cycle, or hold when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// ball_motion: game engine for the one-dimensional LED ping-pong track.
//   clk_6MHz     : system clock (single domain)
//   reset        : synchronous active-high reset
//   btn_l/btn_r  : debounced paddle buttons; only rising edges matter
//   led          : one-hot ball position, bit 0 = left end
//   score_l/_r   : player scores
//   LftCollision : left paddle hit, held for one full step interval
//   RgtCollision : right paddle hit, held for one full step interval
//   game_over    : a score has reached WIN_SCORE
//   winner       : 0 = left, 1 = right; meaningful when game_over
module ball_motion
  import ball_pkg::*;
#(
  parameter int NPOS      = DEF_NPOS,
  parameter int STEP_DIV  = DEF_STEP_DIV,
  parameter int WIN_SCORE = DEF_WIN_SCORE
) (
  input  logic            clk_6MHz,
  input  logic            reset,
  input  logic            btn_l,
  input  logic            btn_r,
  output logic [NPOS-1:0] led,
  output logic [3:0]      score_l,
  output logic [3:0]      score_r,
  output logic            LftCollision,
  output logic            RgtCollision,
  output logic            game_over,
  output logic            winner
);

  localparam int              POS_W     = $clog2(NPOS);
  localparam logic [POS_W-1:0] POS_FIRST = '0;
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(NPOS - 1);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [3:0]       WIN       = 4'(WIN_SCORE);
  localparam logic [NPOS-1:0]  LED_ONE   = NPOS'(1);

  state_e            state_q, state_d;
  logic              serve_q, serve_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [NPOS-1:0]   led_q;
  logic [3:0]        score_l_q, score_l_d;
  logic [3:0]        score_r_q, score_r_d;
  logic              lcol_q, lcol_d;
  logic              rcol_q, rcol_d;
  logic              over_q, over_d;
  logic              winner_q, winner_d;
  logic              btn_l_prev_q, btn_r_prev_q;

  logic              edge_l_s, edge_r_s;
  logic              tick_s, div_clr_s, div_en_s;

  assign edge_l_s = btn_l & ~btn_l_prev_q;
  assign edge_r_s = btn_r & ~btn_r_prev_q;
  assign div_en_s = (state_q == MOVE_R) || (state_q == MOVE_L);

  ball_step_div #(
    .STEP_DIV (STEP_DIV)
  ) u_step_div (
    .clk_i   (clk_6MHz),
    .reset_i (reset),
    .clr_i   (div_clr_s),
    .en_i    (div_en_s),
    .tick_o  (tick_s)
  );

  // Game FSM: serve, step, hit and miss decisions.
  // A hit is tested before the tick so a same-cycle edge counts as a hit.
  always_comb begin
    state_d   = state_q;
    serve_d   = serve_q;
    pos_d     = pos_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    lcol_d    = lcol_q;
    rcol_d    = rcol_q;
    over_d    = over_q;
    winner_d  = winner_q;
    div_clr_s = 1'b0;
    case (state_q)
      IDLE: begin
        if ((serve_q == SIDE_L) && edge_l_s) begin
          state_d   = MOVE_R;
          div_clr_s = 1'b1;
        end else if ((serve_q == SIDE_R) && edge_r_s) begin
          state_d   = MOVE_L;
          div_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      MOVE_R: begin
        if ((pos_q == POS_LAST) && edge_r_s) begin
          state_d   = MOVE_L;
          rcol_d    = 1'b1;
          lcol_d    = 1'b0;
          div_clr_s = 1'b1;
        end else if (tick_s && (pos_q != POS_LAST)) begin
          pos_d  = pos_q + POS_ONE;
          lcol_d = 1'b0;
          rcol_d = 1'b0;
        end else if (tick_s) begin
          // Ball passed the right paddle: left scores, right serves next.
          score_l_d = score_l_q + 4'd1;
          lcol_d    = 1'b0;
          rcol_d    = 1'b0;
          div_clr_s = 1'b1;
          serve_d   = SIDE_R;
          if (score_l_d == WIN) begin
            state_d  = OVER;
            over_d   = 1'b1;
            winner_d = SIDE_L;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = MOVE_R;
        end
      end
      MOVE_L: begin
        if ((pos_q == POS_FIRST) && edge_l_s) begin
          state_d   = MOVE_R;
          lcol_d    = 1'b1;
          rcol_d    = 1'b0;
          div_clr_s = 1'b1;
        end else if (tick_s && (pos_q != POS_FIRST)) begin
          pos_d  = pos_q - POS_ONE;
          lcol_d = 1'b0;
          rcol_d = 1'b0;
        end else if (tick_s) begin
          // Ball passed the left paddle: right scores, left serves next.
          score_r_d = score_r_q + 4'd1;
          lcol_d    = 1'b0;
          rcol_d    = 1'b0;
          div_clr_s = 1'b1;
          serve_d   = SIDE_L;
          if (score_r_d == WIN) begin
            state_d  = OVER;
            over_d   = 1'b1;
            winner_d = SIDE_R;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = MOVE_L;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; button history loads the live levels during reset so a
  // button held through reset never looks like a fresh press.
  always_ff @(posedge clk_6MHz) begin
    if (reset) begin
      state_q      <= IDLE;
      serve_q      <= SIDE_L;
      pos_q        <= POS_FIRST;
      led_q        <= LED_ONE;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
      lcol_q       <= 1'b0;
      rcol_q       <= 1'b0;
      over_q       <= 1'b0;
      winner_q     <= 1'b0;
      btn_l_prev_q <= btn_l;
      btn_r_prev_q <= btn_r;
    end else begin
      state_q      <= state_d;
      serve_q      <= serve_d;
      pos_q        <= pos_d;
      led_q        <= LED_ONE << pos_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      lcol_q       <= lcol_d;
      rcol_q       <= rcol_d;
      over_q       <= over_d;
      winner_q     <= winner_d;
      btn_l_prev_q <= btn_l;
      btn_r_prev_q <= btn_r;
    end
  end

  assign led          = led_q;
  assign score_l      = score_l_q;
  assign score_r      = score_r_q;
  assign LftCollision = lcol_q;
  assign RgtCollision = rcol_q;
  assign game_over    = over_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed vector table plus randomized play, both checked
// every cycle against a behavioural model of the game rules.
module tb_ball_motion;

  localparam int NPOS      = 8;
  localparam int STEP_DIV  = 4;
  localparam int WIN_SCORE = 3;

  logic            clk_6MHz = 1'b0;
  logic            reset    = 1'b1;
  logic            btn_l    = 1'b0;
  logic            btn_r    = 1'b0;
  logic [NPOS-1:0] led;
  logic [3:0]      score_l, score_r;
  logic            LftCollision, RgtCollision, game_over, winner;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_6MHz = ~clk_6MHz;

  ball_motion #(
    .NPOS      (NPOS),
    .STEP_DIV  (STEP_DIV),
    .WIN_SCORE (WIN_SCORE)
  ) dut (
    .clk_6MHz     (clk_6MHz),
    .reset        (reset),
    .btn_l        (btn_l),
    .btn_r        (btn_r),
    .led          (led),
    .score_l      (score_l),
    .score_r      (score_r),
    .LftCollision (LftCollision),
    .RgtCollision (RgtCollision),
    .game_over    (game_over),
    .winner       (winner)
  );

  // ---------------- behavioural model ----------------
  // dir: 0 parked, +1 flying right, -1 flying left. since: cycles since the
  // last step/serve/hit. hold_*: remaining cycles a collision stays visible.
  int m_pos, m_dir, m_server, m_sl, m_sr, m_over, m_win, m_since;
  int m_hold_l, m_hold_r, m_prev_l, m_prev_r;

  task automatic model_edge();
    int el, er;
    bit at_end, hit_btn;
    if (reset) begin
      m_pos = 0; m_dir = 0; m_server = 0; m_sl = 0; m_sr = 0;
      m_over = 0; m_win = 0; m_since = 0; m_hold_l = 0; m_hold_r = 0;
      m_prev_l = int'(btn_l); m_prev_r = int'(btn_r);
    end else begin
      el = (btn_l && m_prev_l == 0) ? 1 : 0;
      er = (btn_r && m_prev_r == 0) ? 1 : 0;
      m_prev_l = int'(btn_l);
      m_prev_r = int'(btn_r);
      if (m_hold_l > 0) m_hold_l--;
      if (m_hold_r > 0) m_hold_r--;
      if (m_over != 0) begin
        // frozen
      end else if (m_dir == 0) begin
        if (m_server == 0 && el == 1) begin m_dir = 1; m_since = 0; end
        else if (m_server == 1 && er == 1) begin m_dir = -1; m_since = 0; end
      end else begin
        at_end  = (m_dir > 0) ? (m_pos == NPOS - 1) : (m_pos == 0);
        hit_btn = (m_dir > 0) ? (er == 1) : (el == 1);
        if (at_end && hit_btn) begin
          if (m_dir > 0) begin m_hold_r = STEP_DIV; m_hold_l = 0; end
          else begin m_hold_l = STEP_DIV; m_hold_r = 0; end
          m_dir = -m_dir;
          m_since = 0;
        end else if (m_since == STEP_DIV - 1) begin
          m_since = 0;
          m_hold_l = 0;
          m_hold_r = 0;
          if (!at_end) begin
            m_pos += m_dir;
          end else if (m_dir > 0) begin
            m_sl++; m_server = 1; m_dir = 0;
            if (m_sl == WIN_SCORE) begin m_over = 1; m_win = 0; end
          end else begin
            m_sr++; m_server = 0; m_dir = 0;
            if (m_sr == WIN_SCORE) begin m_over = 1; m_win = 1; end
          end
        end else begin
          m_since++;
        end
      end
    end
  endtask

  task automatic check(string nm, logic [NPOS-1:0] e_led, logic [3:0] e_sl, logic [3:0] e_sr,
                       logic e_lc, logic e_rc, logic e_go, logic e_win);
    n_cmp++;
    if ({led, score_l, score_r, LftCollision, RgtCollision, game_over, winner} !==
        {e_led, e_sl, e_sr, e_lc, e_rc, e_go, e_win}) begin
      n_bad++;
      $display("FAIL %s @%0t: got led=%b sl=%0d sr=%0d lc=%b rc=%b go=%b win=%b, expected led=%b sl=%0d sr=%0d lc=%b rc=%b go=%b win=%b",
               nm, $time, led, score_l, score_r, LftCollision, RgtCollision, game_over, winner,
               e_led, e_sl, e_sr, e_lc, e_rc, e_go, e_win);
    end
  endtask

  // One clock: advance the model with the applied inputs, then compare.
  task automatic cyc();
    logic [NPOS-1:0] one;
    one = 1;
    model_edge();
    @(posedge clk_6MHz);
    #1;
    check("model", one << m_pos, 4'(m_sl), 4'(m_sr), m_hold_l > 0, m_hold_r > 0,
          m_over != 0, m_win != 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, bl, br;
    int   n;
    logic [7:0] led;
    logic [3:0] sl, sr;
    logic lc, rc, go, win;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rst, logic bl, logic br, int n, logic [7:0] e_led,
                              logic [3:0] sl, logic [3:0] sr, logic lc, logic rc,
                              logic go, logic win);
    vec_t v;
    v.rst = rst; v.bl = bl; v.br = br; v.n = n; v.led = e_led;
    v.sl = sl; v.sr = sr; v.lc = lc; v.rc = rc; v.go = go; v.win = win;
    tbl.push_back(v);
  endfunction

  initial begin
    // reset with btn_l held, no serve, then serve and fly right
    add(1'b1, 1'b1, 1'b0,  2, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0,  6, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0,  1, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0,  1, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0,  3, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0,  1, 8'h02, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 24, 8'h80, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // right hit: collision held 4 cycles, drops as ball steps to 6
    add(1'b0, 1'b0, 1'b1,  1, 8'h80, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0,  3, 8'h80, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0,  1, 8'h40, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // miss at the right end, then only the right player may serve
    add(1'b1, 1'b0, 1'b0,  2, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0,  1, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 28, 8'h80, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0,  4, 8'h80, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0,  3, 8'h80, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1,  1, 8'h80, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0,  4, 8'h40, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // hit edge in the same cycle as the tick at pos 7 counts as a hit
    add(1'b1, 1'b0, 1'b0,  2, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0,  1, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 28, 8'h80, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0,  3, 8'h80, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1,  1, 8'h80, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0,  4, 8'h40, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // left wins 3-0
    add(1'b1, 1'b0, 1'b0,  2, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0,  1, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32, 8'h80, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1,  1, 8'h80, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 28, 8'h01, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0,  1, 8'h01, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32, 8'h80, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1,  1, 8'h80, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 28, 8'h01, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0,  1, 8'h01, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32, 8'h80, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1,  3, 8'h80, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    // reset out of OVER, then reset mid-rally with a pending collision
    add(1'b1, 1'b0, 1'b0,  1, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0,  1, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 28, 8'h80, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1,  1, 8'h80, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0,  1, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      btn_l = tbl[i].bl;
      btn_r = tbl[i].br;
      for (int c = 0; c < tbl[i].n; c++) cyc();
      check($sformatf("row%0d", i + 1), tbl[i].led, tbl[i].sl, tbl[i].sr,
            tbl[i].lc, tbl[i].rc, tbl[i].go, tbl[i].win);
    end

    // ---------------- randomized play ----------------
    reset = 1'b1;
    btn_l = 1'b0;
    btn_r = 1'b0;
    cyc();
    for (int i = 0; i < 6000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) btn_l = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) btn_r = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
